// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for alu_with_reg datapath controllers.
// FSM state encoding, mux select constants, latched command flags.
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_CARRY  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic DP_SEL_ALU = 1'b0;
  localparam logic DP_SEL_IN  = 1'b1;

  typedef struct packed {
    logic op;
    logic wb;
  } cmd_flags_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for alu_with_reg: load A, load B,
// execute, capture carry, then present result on res_*.
import alu_seq_ctrl_pkg::*;

module alu_seq_ctrl #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BIT_WIDTH-1:0] req_a,
  input  logic [BIT_WIDTH-1:0] req_b,
  input  logic                 req_op,
  input  logic                 req_wb,
  input  logic                 req_acc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BIT_WIDTH-1:0] res_data,
  output logic                 res_cout,
  output logic                 busy,
  output logic [BIT_WIDTH-1:0] dp_in,
  output logic                 dp_s_reg,
  output logic                 dp_en_ra,
  output logic                 dp_en_rb,
  output logic                 dp_s,
  input  logic [BIT_WIDTH-1:0] dp_out,
  input  logic                 dp_cout
);

  state_t               state_q;
  state_t               state_d;
  logic [BIT_WIDTH-1:0] a_q;
  logic [BIT_WIDTH-1:0] b_q;
  cmd_flags_t           cmd_q;
  logic                 acc_ok_q;
  logic                 accept;

  assign accept = (state_q == ST_IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      acc_ok_q <= 1'b0;
      res_data <= '0;
      res_cout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= req_a;
        b_q      <= req_b;
        cmd_q.op <= req_op;
        cmd_q.wb <= req_wb;
      end
      if (state_q == ST_EXEC) begin
        res_data <= dp_out;
        acc_ok_q <= cmd_q.wb;
      end
      // dp_cout is the carry registered at the end of EXEC
      if (state_q == ST_CARRY) begin
        res_cout <= dp_cout;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    dp_in     = '0;
    dp_s_reg  = DP_SEL_ALU;
    dp_en_ra  = 1'b0;
    dp_en_rb  = 1'b0;
    dp_s      = cmd_q.op;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        dp_s      = 1'b0;
        if (req_valid) begin
          state_d = (req_acc && acc_ok_q) ? ST_LOAD_B
                                          : ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        dp_in    = a_q;
        dp_s_reg = DP_SEL_IN;
        dp_en_ra = 1'b1;
        state_d  = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        dp_in    = b_q;
        dp_s_reg = DP_SEL_IN;
        dp_en_rb = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        dp_en_ra = cmd_q.wb;
        state_d  = ST_CARRY;
      end
      ST_CARRY: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        dp_s    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Command sequencer for the ALU/register datapath (alu_with_reg): mux select, A/B register enables, ALU select and operand input.
- Accepts one command per valid/ready handshake, then sequences: load A, load B, execute, capture carry.
- Returns result and carry on a valid/ready result channel.
- Optional accumulate mode: write the result back into A and reuse it as the next command's A operand.

Parameters:
- BIT_WIDTH, 4, operand/result width; must match the datapath instance.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  controller can accept a command.
- req_a  in  BIT_WIDTH  operand A.
- req_b  in  BIT_WIDTH  operand B.
- req_op  in  1  ALU select, passed to datapath s uninterpreted.
- req_wb  in  1  write result back into register A.
- req_acc  in  1  reuse register A contents as operand A (skip A load).
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_data  out  BIT_WIDTH  captured ALU result.
- res_cout  out  1  captured carry.
- busy  out  1  high in every state except IDLE.
- dp_in  out  BIT_WIDTH  to datapath in.
- dp_s_reg  out  1  to datapath s_reg (1 = external input, 0 = ALU result).
- dp_en_ra  out  1  to datapath en_ra.
- dp_en_rb  out  1  to datapath en_rb.
- dp_s  out  1  to datapath s.
- dp_out  in  BIT_WIDTH  from datapath out (combinational ALU result).
- dp_cout  in  1  from datapath cout (registered one cycle after the ALU).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - res_valid, res_data, res_cout, busy, dp_* = 0.
  - acc_ok = 0; latched cmd = 0.
  - Datapath registers are not reset; the controller never relies on their contents unless acc_ok = 1.
- States: IDLE, LOAD_A, LOAD_B, EXEC, CARRY, DONE. All outputs are registered or decoded from state plus the latched command.
- IDLE:
  - req_ready = 1; all dp enables 0.
  - On req_valid: latch a, b, op, wb, acc.
  - Next state is LOAD_B if acc && acc_ok, else LOAD_A.
- LOAD_A: dp_in = a, dp_s_reg = 1, dp_en_ra = 1 -> LOAD_B.
- LOAD_B: dp_in = b, dp_s_reg = 1, dp_en_rb = 1 -> EXEC.
- EXEC:
  - dp_s = op; res_data <= dp_out at the closing edge.
  - If wb: dp_s_reg = 0, dp_en_ra = 1 (result into A) and acc_ok <= 1; else acc_ok <= 0.
  - -> CARRY.
- CARRY:
  - dp_s = op; res_cout <= dp_cout. This is the carry registered at the end of EXEC, so it pairs with res_data.
  - -> DONE.
- DONE:
  - res_valid = 1; res_data and res_cout held stable.
  - On res_ready: -> IDLE, res_valid drops next cycle.
- dp_s = latched op in every non-IDLE state; dp_in = 0 when not loading.
- Latency, from the accept edge to first res_valid cycle: 4 cycles normal, 3 cycles with an honoured acc.
- Throughput: one command per 5 cycles minimum (IDLE is mandatory between commands).
- Boundaries:
  - req_acc with acc_ok = 0 (after reset, or after a non-wb command): treated as a normal command, A is loaded from req_a.
  - res_ready already high on DONE entry: res_valid is a single-cycle pulse.
  - res_ready low: DONE holds indefinitely; req_ready stays 0.
  - req_valid outside IDLE: ignored.
  - req_* changing after accept: no effect.
  - Reset mid-command: immediate return to IDLE, all enables drop asynchronously, no partial result is presented.
  - Exactly one of dp_en_ra/dp_en_rb is high per cycle, and only in LOAD_A, LOAD_B or EXEC-with-wb.

Decomposition:
- Shared header: state localparams (3-bit binary: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, CARRY=4, DONE=5) and DP_SEL_ALU=0 / DP_SEL_IN=1 constants for s_reg, reusable by other datapath controllers.
- No sub-module needed; a single FSM plus a command latch.
- Integration top instantiates alu_seq_ctrl next to alu_with_reg.

Test Plan:
- The bench datapath is alu_with_reg, BIT_WIDTH = 4; expected values assume op 0 = add.
- Reset mid-EXEC -> outputs and enables 0 within the same cycle; the next command does a full A load even with req_acc = 1.
- Command a=5, b=3, op=0, wb=0 -> res_valid on 4th cycle after accept, res_data=8, res_cout=0; enable pattern en_ra, en_rb, none, none.
- a=9, b=8, op=0 -> res_data=1, res_cout=1, proving carry/result pairing across CARRY.
- a=2, b=3, wb=1, then acc=1, b=4 -> second result 9 (5+4); LOAD_A skipped, latency 3.
- acc=1 right after reset with a=7, b=1 -> LOAD_A executes, result 8.
- res_ready held low 10 cycles, req_valid pulsed during DONE -> res_valid and res_data stable, req_ready 0, command ignored; then res_ready=1 -> IDLE next cycle.
